// File: rtl/ula_serial_ctrl_if.sv
// ula_serial_ctrl_if: request/response bus between ALU control logic and the serial ALU sequencer
interface ula_serial_ctrl_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry_out;
  logic             op_err;
  modport master (output start, op, a, b, input busy, done, result, zero, carry_out, op_err);
  modport slave (input start, op, a, b, output busy, done, result, zero, carry_out, op_err);
endinterface

// File: rtl/ula_serial_ctrl.sv
// ula_serial_ctrl: bit-serial ALU sequencer driving a 1-bit ULA slice LSB-first
module ula_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  ula_serial_ctrl_if.slave     bus,
  output logic [2:0]           slice_ALUcontrol,
  output logic                 slice_A,
  output logic                 slice_B,
  output logic                 slice_cin,
  output logic                 slice_addSub,
  input  logic                 slice_ALUresult
);
  localparam int AW = $clog2(WIDTH);
  // ERR is a one-cycle bubble so an invalid op reports done two cycles after accept
  typedef enum logic [1:0] {IDLE, RUN, ERR, DONE} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] a_q, b_q, res_n, fin;
  logic [2:0]       op_q;
  logic [AW:0]      cnt;
  logic             carry, carry_n, ai, bi, valid, last, slt_bit;
  assign valid   = bus.op inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
  assign ai      = a_q[cnt[AW-1:0]];
  assign bi      = b_q[cnt[AW-1:0]] ^ op_q[2];
  assign carry_n = (ai & bi) | (ai & carry) | (bi & carry);
  assign last    = cnt == (AW+1)'(WIDTH - 1);
  assign res_n   = bus.result | ({{(WIDTH-1){1'b0}}, slice_ALUresult} << cnt);
  // SLT sign corrected by overflow (carry into MSB xor carry out of MSB)
  assign slt_bit = slice_ALUresult ^ carry ^ carry_n;
  assign fin     = op_q == 3'b111 ? {{(WIDTH-1){1'b0}}, slt_bit} : res_n;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state == IDLE ? (bus.start ? (valid ? RUN : ERR) : IDLE)
            : state == RUN  ? (last ? DONE : RUN)
            : state == ERR  ? DONE : IDLE;
  end
  always_comb begin
    bus.busy         = state == RUN;
    bus.done         = state == DONE;
    slice_ALUcontrol = state == RUN ? (op_q == 3'b111 ? 3'b110 : op_q) : 3'b000;
    slice_A          = state == RUN && ai;
    slice_B          = state == RUN && b_q[cnt[AW-1:0]];
    slice_cin        = state == RUN && carry;
    slice_addSub     = slice_ALUcontrol[2];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      cnt           <= '0;
      carry         <= 1'b0;
      bus.result    <= '0;
      bus.zero      <= 1'b0;
      bus.carry_out <= 1'b0;
      bus.op_err    <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      a_q           <= bus.a;
      b_q           <= bus.b;
      op_q          <= bus.op;
      cnt           <= '0;
      carry         <= bus.op[2] & bus.op[1];
      bus.result    <= '0;
      bus.zero      <= !valid;
      bus.carry_out <= 1'b0;
      bus.op_err    <= !valid;
    end else if (state == RUN) begin
      bus.result <= last ? fin : res_n;
      carry      <= carry_n;
      cnt        <= cnt + 1'b1;
      if (last) begin
        bus.zero      <= fin == '0;
        bus.carry_out <= op_q[1] & carry_n;
      end
    end
  end
endmodule

// File: tb/tb_ula_serial_ctrl.sv
// tb_ula_serial_ctrl: directed vectors for the serial ALU sequencer against a behavioural 1-bit slice
module tb_ula_serial_ctrl;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  ula_serial_ctrl_if #(.WIDTH(W)) bus();
  logic [2:0] s_ctl;
  logic       s_a, s_b, s_cin, s_as, s_res, bb;
  ula_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .slice_ALUcontrol(s_ctl), .slice_A(s_a), .slice_B(s_b), .slice_cin(s_cin),
    .slice_addSub(s_as), .slice_ALUresult(s_res)
  );
  // 1-bit slice: AND / OR / full adder with B inverted under addSub
  assign bb    = s_b ^ s_as;
  assign s_res = s_ctl[1] ? (s_a ^ bb ^ s_cin) : s_ctl[0] ? (s_a | s_b) : (s_a & s_b);
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [11:0] flags();
    return {bus.busy, bus.done, bus.zero, bus.carry_out, bus.op_err, s_ctl, s_a, s_b, s_cin, s_as};
  endfunction
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic slice_seen);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    @(posedge clk);
    #1 bus.start = 1'b0; bus.op = 3'b101; bus.a = $urandom; bus.b = $urandom;
    lat = 0;
    slice_seen = 1'b0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      slice_seen |= |{s_ctl, s_a, s_b, s_cin, s_as};
      if (bus.done) break;
    end
  endtask
  typedef struct {
    string      nm;
    logic [2:0] op;
    logic [31:0] a, b, res;
    logic       z, c, e;
  } vec_t;
  vec_t v[$];
  int lat, n_done;
  logic seen;
  initial begin
    bus.start = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0;
    v.push_back('{"add5_3",   3'b010, 32'h5,        32'h3,        32'h8,        1'b0, 1'b0, 1'b0});
    v.push_back('{"sub3_5",   3'b110, 32'h3,        32'h5,        32'hFFFFFFFE, 1'b0, 1'b0, 1'b0});
    v.push_back('{"sub_eq",   3'b110, 32'h1234,     32'h1234,     32'h0,        1'b1, 1'b1, 1'b0});
    v.push_back('{"slt_m1_1", 3'b111, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b1, 1'b0});
    v.push_back('{"slt_ovf",  3'b111, 32'h7FFFFFFF, 32'h80000000, 32'h0,        1'b1, 1'b0, 1'b0});
    v.push_back('{"slt_ovf2", 3'b111, 32'h80000000, 32'h7FFFFFFF, 32'h1,        1'b0, 1'b1, 1'b0});
    v.push_back('{"slt_3_5",  3'b111, 32'h3,        32'h5,        32'h1,        1'b0, 1'b0, 1'b0});
    v.push_back('{"slt_5_5",  3'b111, 32'h5,        32'h5,        32'h0,        1'b1, 1'b1, 1'b0});
    v.push_back('{"and",      3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0});
    v.push_back('{"or",       3'b001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0});
    v.push_back('{"add_wrap", 3'b010, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b1, 1'b0});
    v.push_back('{"add_sovf", 3'b010, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b0, 1'b0});
    v.push_back('{"inv100",   3'b100, 32'h5,        32'h3,        32'h0,        1'b1, 1'b0, 1'b1});
    v.push_back('{"inv011",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 1'b1});
    v.push_back('{"add_clr",  3'b010, 32'h5,        32'h3,        32'h8,        1'b0, 1'b0, 1'b0});
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_flags", 32'(flags()), 32'h0);
    chk("reset_result", bus.result, 32'h0);
    reset = 1'b0;
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, lat, seen);
      chk({v[i].nm, "_latency"}, lat, v[i].e ? 32'd2 : 32'd33);
      chk({v[i].nm, "_result"}, bus.result, v[i].res);
      chk({v[i].nm, "_zco_err"}, {bus.zero, bus.carry_out, bus.op_err}, {v[i].z, v[i].c, v[i].e});
      if (v[i].e) chk({v[i].nm, "_slice_quiet"}, seen, 1'b0);
      @(negedge clk);
      chk({v[i].nm, "_done_pulse"}, {bus.done, bus.busy}, 2'b00);
      chk({v[i].nm, "_held"}, bus.result, v[i].res);
    end
    // start pulsed mid-run with new operands must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'h5; bus.b = 32'h3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 5) begin
        chk("midrun_busy", bus.busy, 1'b1);
        bus.start = 1'b1; bus.op = 3'b110; bus.a = 32'h9; bus.b = 32'h2;
        @(posedge clk);
        #1 bus.start = 1'b0;
        continue;
      end
      if (bus.done) break;
    end
    chk("midrun_latency", lat, 32'd33);
    chk("midrun_result", bus.result, 32'h8);
    // reset around bit 10 aborts the run with no done pulse
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'hFFFFFFFF; bus.b = 32'h1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_flags", 32'(flags()), 32'h0);
    chk("abort_result", bus.result, 32'h0);
    reset = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) n_done++;
    end
    chk("abort_no_done", n_done, 32'd0);
    run_op(3'b110, 32'h3, 32'h5, lat, seen);
    chk("after_reset_latency", lat, 32'd33);
    chk("after_reset_result", bus.result, 32'hFFFFFFFE);
    chk("after_reset_zco_err", {bus.zero, bus.carry_out, bus.op_err}, 3'b000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
